mm_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the 64-byte byte-accessible synchronous memory (MM).
- Each requester issues single-byte read or write transactions over a req/ack handshake.
- The arbiter serialises them onto the memory's single port, drives exactly one of mem_write_enable/mem_read_enable per access, and returns read data with a one-cycle ack pulse.

---
 rtl/mm_rr_arbiter_if.sv | 39 +++
 rtl/mm_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mm_rr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_rr_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port round-robin byte-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus the memory.
interface mm_rr_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_read_data,
    output ack0, rdata0, ack1, rdata1, mem_address, mem_write_data,
    output mem_write_enable, mem_read_enable, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_read_data,
    input  ack0, rdata0, ack1, rdata1, mem_address, mem_write_data,
    input  mem_write_enable, mem_read_enable, busy
  );
endinterface

// File: rtl/mm_rr_arbiter.sv
// Two-requester round-robin arbiter serialising single-byte reads/writes onto a synchronous
// memory port. Each transaction walks IDLE -> ISSUE -> WAIT -> RESP; all outputs are registered.
module mm_rr_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input logic            clk,
  input logic            rst,
  mm_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            r_state,      w_state_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic              r_gnt,        w_gnt_nxt;
  logic              r_we,         w_we_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic [DATA_W-1:0] r_wdata,      w_wdata_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic              r_mem_re,     w_mem_re_nxt;
  logic              r_ack0,       w_ack0_nxt;
  logic              r_ack1,       w_ack1_nxt;
  logic [DATA_W-1:0] r_rdata0,     w_rdata0_nxt;
  logic [DATA_W-1:0] r_rdata1,     w_rdata1_nxt;

  logic              w_sel;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Contention goes to the requester not granted last; a lone requester always wins.
  always_comb begin
    w_sel       = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;
    w_sel_we    = w_sel ? bus.we1    : bus.we0;
    w_sel_addr  = w_sel ? bus.addr1  : bus.addr0;
    w_sel_wdata = w_sel ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_gnt_nxt        = r_gnt;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_mem_we_nxt     = 1'b0;
    w_mem_re_nxt     = 1'b0;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_rdata0_nxt     = r_rdata0;
    w_rdata1_nxt     = r_rdata1;
    unique case (r_state)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          w_gnt_nxt        = w_sel;
          w_last_grant_nxt = w_sel;
          w_we_nxt         = w_sel_we;
          w_addr_nxt       = w_sel_addr;
          w_wdata_nxt      = w_sel_wdata;
          w_mem_we_nxt     = w_sel_we;
          w_mem_re_nxt     = ~w_sel_we;
          w_state_nxt      = StIssue;
        end
      end
      StIssue: w_state_nxt = StWait;
      StWait: begin
        // Memory registered its read data on the edge that ended ISSUE.
        if (!r_we) begin
          if (r_gnt) w_rdata1_nxt = bus.mem_read_data;
          else       w_rdata0_nxt = bus.mem_read_data;
        end
        w_ack0_nxt  = ~r_gnt;
        w_ack1_nxt  = r_gnt;
        w_state_nxt = StResp;
      end
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt        <= w_gnt_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_re     <= w_mem_re_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_rdata0     <= w_rdata0_nxt;
      r_rdata1     <= w_rdata1_nxt;
    end
  end

  assign bus.ack0             = r_ack0;
  assign bus.ack1             = r_ack1;
  assign bus.rdata0           = r_rdata0;
  assign bus.rdata1           = r_rdata1;
  assign bus.mem_address      = r_addr;
  assign bus.mem_write_data   = r_wdata;
  assign bus.mem_write_enable = r_mem_we;
  assign bus.mem_read_enable  = r_mem_re;
  assign bus.busy             = (r_state != StIdle);

endmodule

// File: tb/tb_mm_rr_arbiter.sv
// Bench for mm_rr_arbiter: behavioural 64-byte memory, reference memory and an expected-ack
// scoreboard filled as transactions are issued and drained as acks come back.
module tb_mm_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mm_rr_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  mm_rr_arbiter #(.ADDR_W(6), .DATA_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  logic [7:0] mem_rd;
  assign bus.mem_read_data = mem_rd;
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
    if (bus.mem_read_enable)  mem_rd <= mem[bus.mem_address];
  end

  typedef struct {
    int         who;
    bit         rd;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int rem0, rem1;
  int n_ack, cnt_we, cnt_re, both_hi, dbl, idle_mid, first_busy;
  logic [5:0] we_addr, re_addr;
  logic [7:0] we_data;
  int ack_who [16];
  int ack_cyc [16];
  logic [7:0] ack_data [16];

  task automatic start(input int who, input bit we, input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    e.who  = who;
    e.rd   = !we;
    e.data = we ? d : ref_mem[a];
    if (we) ref_mem[a] = d;
    exp_q.push_back(e);
    if (who == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; rem0++;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; rem1++;
    end
  endtask

  // Runs the clock until n acks are seen, recording memory-port activity along the way.
  task automatic serve(input int n, input int budget);
    int cyc = 0;
    n_ack = 0; cnt_we = 0; cnt_re = 0; both_hi = 0; dbl = 0; idle_mid = 0; first_busy = -1;
    while (n_ack < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_write_enable) begin
        cnt_we++; we_addr = bus.mem_address; we_data = bus.mem_write_data;
      end
      if (bus.mem_read_enable) begin
        cnt_re++; re_addr = bus.mem_address;
      end
      if (bus.mem_write_enable && bus.mem_read_enable) both_hi++;
      if (bus.ack0 && bus.ack1) dbl++;
      if (!bus.busy && first_busy >= 0) idle_mid++;
      if (bus.busy && first_busy < 0) first_busy = cyc;
      if (bus.ack0) begin
        ack_who[n_ack] = 0; ack_data[n_ack] = bus.rdata0; ack_cyc[n_ack] = cyc; n_ack++;
        rem0--;
        if (rem0 <= 0) bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        ack_who[n_ack] = 1; ack_data[n_ack] = bus.rdata1; ack_cyc[n_ack] = cyc; n_ack++;
        rem1--;
        if (rem1 <= 0) bus.req1 = 1'b0;
      end
    end
    if (n_ack < n) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: got %0d acks want %0d", n_ack, n);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    rem0 = 0; rem1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    rst = 1'b0;
    #1;
    obs = {bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.mem_address, bus.mem_write_data,
           bus.mem_write_enable, bus.mem_read_enable, bus.busy};
    n_vec++;
    if (obs !== 37'd0) begin
      n_err++; $display("FAIL reset_outputs: got %0h want 0", obs);
    end
    reset_dut();
  endtask

  task automatic test_write();
    exp_t e;
    @(negedge clk);
    start(0, 1'b1, 6'h01, 8'h55);
    serve(1, 20);
    n_vec++;
    if (cnt_we !== 1 || we_addr !== 6'h01 || we_data !== 8'h55 || cnt_re !== 0) begin
      n_err++;
      $display("FAIL write_port: got we=%0d addr=%0h data=%0h re=%0d want 1 01 55 0",
               cnt_we, we_addr, we_data, cnt_re);
    end
    n_vec++;
    if (ack_cyc[0] !== 3) begin
      n_err++; $display("FAIL write_latency: got %0d want 3", ack_cyc[0]);
    end
    e = exp_q.pop_front();
    n_vec++;
    if (ack_who[0] !== e.who) begin
      n_err++; $display("FAIL write_ack_who: got %0d want %0d", ack_who[0], e.who);
    end
  endtask

  task automatic test_read_after_write();
    exp_t e;
    @(negedge clk);
    start(1, 1'b1, 6'h03, 8'h75);
    serve(1, 20);
    e = exp_q.pop_front();
    n_vec++;
    if (ack_who[0] !== e.who) begin
      n_err++; $display("FAIL raw_write_who: got %0d want %0d", ack_who[0], e.who);
    end
    @(negedge clk);
    start(0, 1'b0, 6'h03, 8'h00);
    serve(1, 20);
    n_vec++;
    if (cnt_re !== 1 || cnt_we !== 0 || re_addr !== 6'h03) begin
      n_err++;
      $display("FAIL read_port: got re=%0d we=%0d addr=%0h want 1 0 03", cnt_re, cnt_we, re_addr);
    end
    e = exp_q.pop_front();
    n_vec++;
    if (ack_who[0] !== e.who || ack_data[0] !== e.data) begin
      n_err++;
      $display("FAIL read_data: got who=%0d data=%0h want who=%0d data=%0h",
               ack_who[0], ack_data[0], e.who, e.data);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    reset_dut();
    start(0, 1'b1, 6'h10, 8'hAA);
    start(1, 1'b0, 6'h10, 8'h00);
    serve(2, 30);
    for (int i = 0; i < n_ack; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (ack_who[i] !== e.who || (e.rd && ack_data[i] !== e.data)) begin
        n_err++;
        $display("FAIL contention_%0d: got who=%0d data=%0h want who=%0d data=%0h",
                 i, ack_who[i], ack_data[i], e.who, e.data);
      end
    end
    n_vec++;
    if (ack_cyc[1] - ack_cyc[0] !== 4) begin
      n_err++; $display("FAIL contention_gap: got %0d want 4", ack_cyc[1] - ack_cyc[0]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start(0, 1'b1, 6'h20, 8'h33);
      start(1, 1'b0, 6'h20, 8'h00);
    end
    serve(6, 60);
    for (int i = 0; i < n_ack; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (ack_who[i] !== e.who || (e.rd && ack_data[i] !== e.data)) begin
        n_err++;
        $display("FAIL fair_%0d: got who=%0d data=%0h want who=%0d data=%0h",
                 i, ack_who[i], ack_data[i], e.who, e.data);
      end
    end
    n_vec++;
    if (both_hi !== 0 || dbl !== 0) begin
      n_err++; $display("FAIL fair_exclusive: got both=%0d dblack=%0d want 0 0", both_hi, dbl);
    end
    n_vec++;
    if (idle_mid !== 5 || first_busy !== 1 || ack_cyc[5] !== 23) begin
      n_err++;
      $display("FAIL fair_busy: got idle=%0d first=%0d last=%0d want 5 1 23",
               idle_mid, first_busy, ack_cyc[5]);
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    logic [5:0] a [4] = '{6'h3F, 6'h00, 6'h3F, 6'h00};
    logic [7:0] d [4] = '{8'hC3, 8'h5A, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start(0, (i < 2), a[i], d[i]);
      serve(1, 20);
      e = exp_q.pop_front();
      n_vec++;
      if ((i < 2 ? we_addr : re_addr) !== a[i] || (e.rd && ack_data[0] !== e.data)) begin
        n_err++;
        $display("FAIL boundary_%0d: got addr=%0h data=%0h want addr=%0h data=%0h",
                 i, (i < 2 ? we_addr : re_addr), ack_data[0], a[i], e.data);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    logic [36:0] obs;
    int stray = 0;
    @(negedge clk);
    start(1, 1'b0, 6'h10, 8'h00);
    @(negedge clk);
    n_vec++;
    if (bus.mem_read_enable !== 1'b1) begin
      n_err++; $display("FAIL rst_issue_re: got %0b want 1", bus.mem_read_enable);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    obs = {bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.mem_address, bus.mem_write_data,
           bus.mem_write_enable, bus.mem_read_enable, bus.busy};
    n_vec++;
    if (obs !== 37'd0) begin
      n_err++; $display("FAIL rst_async_outputs: got %0h want 0", obs);
    end
    bus.req1 = 1'b0;
    rem1 = 0;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_err++; $display("FAIL rst_no_ack: got %0d acks want 0", stray);
    end
    start(0, 1'b0, 6'h3F, 8'h00);
    start(1, 1'b0, 6'h00, 8'h00);
    serve(2, 30);
    for (int i = 0; i < n_ack; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (ack_who[i] !== e.who || ack_data[i] !== e.data) begin
        n_err++;
        $display("FAIL rst_resume_%0d: got who=%0d data=%0h want who=%0d data=%0h",
                 i, ack_who[i], ack_data[i], e.who, e.data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem_rd = 8'h00;
    reset_dut();
    test_reset();
    test_write();
    test_read_after_write();
    test_contention();
    test_back_to_back();
    test_boundary();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
